cdb_arbiter: RTL

Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order functional units (ALU, MUL, DIV, LSU). Each cycle it grants at most one pending completion and drives the registered broadcast (valid, tag, data) consumed by the register status table, the reservation stations and the register file write port. It is the sole source of `cdb_valid`/`cdb_tag` in the back end.

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/cdb_rr_pick.sv | 45 ++++
 rtl/cdb_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Common data bus constants and broadcast record, shared by the arbiter, the
// register status table and the reservation stations.
package cdb_pkg;

    localparam int CDB_N_REQ  = 4;
    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

    // Width of a unit index; a single-bit index is kept even for degenerate sizes.
    function automatic int cdb_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot back and report its index.
module cdb_rr_pick
    import cdb_pkg::*;
#(
    parameter int N_REQ = CDB_N_REQ,
    localparam int PTR_W = cdb_ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] winner
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] rot_oh;
    logic [PTR_W-1:0] offset;
    logic [PTR_W:0]   sum;
    logic             hit;

    always_comb begin
        rot    = (req >> rr_ptr) | (req << (N_REQ - int'(rr_ptr)));
        rot_oh = '0;
        offset = '0;
        hit    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!hit && rot[i]) begin
                hit       = 1'b1;
                rot_oh[i] = 1'b1;
                offset    = PTR_W'(i);
            end
        end
        grant = (rot_oh << rr_ptr) | (rot_oh >> (N_REQ - int'(rr_ptr)));

        // Modulo add without a divider; rr_ptr and offset are both below N_REQ.
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        winner = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational grant, registered broadcast.
// Define CDB_ARB_PERF_EN to add the saturating contention counter port.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_grant,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [15:0]             perf_conflict_cnt
`endif
);

    localparam int PTR_W = cdb_ptr_w(N_REQ);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  next_ptr;
    logic [N_REQ-1:0]  req_live;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic              any_grant;

    // Reset and flush mask requests before the picker so no grant escapes.
    assign req_live = (rst || flush) ? '0 : req_valid;

    cdb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_live),
        .rr_ptr (rr_ptr),
        .grant  (req_grant),
        .winner (winner)
    );

    assign any_grant = |req_grant;
    assign next_ptr  = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_grant[i]) begin
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= any_grant;
            if (any_grant) begin
                rr_ptr   <= next_ptr;
                cdb_tag  <= sel_tag;
                cdb_data <= sel_data;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic [15:0] perf_cnt_q;
    logic        contention;

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign contention = |(req_valid & (req_valid - N_REQ'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
        end else if (!flush && contention && (perf_cnt_q != 16'hFFFF)) begin
            perf_cnt_q <= perf_cnt_q + 16'd1;
        end
    end

    assign perf_conflict_cnt = perf_cnt_q;
`endif

endmodule
